// File: rtl/lif_pkg.sv
// Shared types and defaults for the time-multiplexed LIF neuron scheduler.
// Optional refractory behaviour is selected with the LIF_REFRACTORY_EN macro.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lif_state_e;

  localparam int LIF_W          = 8;
  localparam int LIF_THRESHOLD  = 200;
  localparam int LIF_LEAK_SHIFT = 2;

  // Unsigned add clamped to 2^w-1; operands are zero-extended, w <= 16.
  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input int unsigned w);
    logic [16:0] sum;
    logic [16:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (17'd1 << w) - 17'd1;
    return (sum > max_v) ? max_v[15:0] : sum[15:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational leak/integrate/threshold datapath shared by all virtual neurons.
// With LIF_REFRACTORY_EN defined, a 2-bit refractory count suppresses updates.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int W          = LIF_W,
  parameter int THRESHOLD  = LIF_THRESHOLD,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
  input  logic [W-1:0] state_in,
  input  logic [W-1:0] acc_in,
  input  logic [1:0]   refr_in,
  output logic [W-1:0] state_out,
  output logic         spike,
  output logic [1:0]   refr_out
);

  localparam logic [W:0] THR = (W+1)'(THRESHOLD);

  logic [W-1:0] leaked;
  logic [W-1:0] v;
  logic         fire;

  always_comb begin
    leaked = state_in - (state_in >> LEAK_SHIFT);
    v      = W'(sat_add(16'(leaked), 16'(acc_in), W));
    fire   = ({1'b0, v} >= THR);

    state_out = v;
    spike     = 1'b0;
    refr_out  = 2'd0;
`ifdef LIF_REFRACTORY_EN
    if (refr_in != 2'd0) begin
      state_out = '0;
      refr_out  = refr_in - 2'd1;
    end else if (fire) begin
      state_out = '0;
      spike     = 1'b1;
      refr_out  = 2'd2;
    end
`else
    if (fire) begin
      state_out = '0;
      spike     = 1'b1;
    end
`endif
  end

`ifndef LIF_REFRACTORY_EN
  logic unused_refr;
  assign unused_refr = ^refr_in;
`endif

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons through one shared update core per tick,
// buffering injected current and emitting spikes over a valid/ready port.
// Optional refractory counters are enabled with LIF_REFRACTORY_EN.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int W          = LIF_W,
  parameter int THRESHOLD  = LIF_THRESHOLD,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
  localparam int IW        = $clog2(N_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cur_valid,
  input  logic [IW-1:0] cur_idx,
  input  logic [W-1:0]  cur_data,
  output logic          cur_ready,
  input  logic          tick,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic          spk_valid,
  output logic [IW-1:0] spk_idx,
  input  logic          spk_ready,
  input  logic [IW-1:0] mon_idx,
  output logic [W-1:0]  mon_state
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  lif_state_e    fsm_q, fsm_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  state_q [N_NEURONS];
  logic [W-1:0]  state_d [N_NEURONS];
  logic [W-1:0]  acc_q   [N_NEURONS];
  logic [W-1:0]  acc_d   [N_NEURONS];
  logic          spk_valid_q, spk_valid_d;
  logic [IW-1:0] spk_idx_q, spk_idx_d;
  logic          overrun_q, overrun_d;
  logic [W-1:0]  mon_state_q, mon_state_d;

  logic [W-1:0]  core_state;
  logic          core_spike;
  logic [1:0]    core_refr_in;
  logic [1:0]    core_refr_out;
  logic          commit;

`ifdef LIF_REFRACTORY_EN
  logic [1:0] refr_q [N_NEURONS];
  logic [1:0] refr_d [N_NEURONS];
  assign core_refr_in = refr_q[idx_q];
`else
  logic unused_core_refr;
  assign core_refr_in     = 2'd0;
  assign unused_core_refr = ^core_refr_out;
`endif

  lif_update_core #(
    .W         (W),
    .THRESHOLD (THRESHOLD),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_core (
    .state_in (state_q[idx_q]),
    .acc_in   (acc_q[idx_q]),
    .refr_in  (core_refr_in),
    .state_out(core_state),
    .spike    (core_spike),
    .refr_out (core_refr_out)
  );

  // A spiking neuron may only commit when the output register frees up this cycle.
  assign commit = (fsm_q == SWEEP) && (!core_spike || !spk_valid_q || spk_ready);

  always_comb begin
    fsm_d       = fsm_q;
    idx_d       = idx_q;
    state_d     = state_q;
    acc_d       = acc_q;
    spk_valid_d = spk_valid_q;
    spk_idx_d   = spk_idx_q;
    overrun_d   = overrun_q;
    mon_state_d = state_q[mon_idx];
`ifdef LIF_REFRACTORY_EN
    refr_d      = refr_q;
`endif

    if (spk_valid_q && spk_ready) begin
      spk_valid_d = 1'b0;
    end

    case (fsm_q)
      IDLE: begin
        if (cur_valid) begin
          acc_d[cur_idx] = W'(sat_add(16'(acc_q[cur_idx]), 16'(cur_data), W));
        end
        if (tick) begin
          fsm_d = SWEEP;
          idx_d = '0;
        end
      end
      SWEEP: begin
        if (tick) overrun_d = 1'b1;
        if (commit) begin
          state_d[idx_q] = core_state;
          acc_d[idx_q]   = '0;
`ifdef LIF_REFRACTORY_EN
          refr_d[idx_q]  = core_refr_out;
`endif
          if (core_spike) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            fsm_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (tick) overrun_d = 1'b1;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      spk_valid_q <= 1'b0;
      spk_idx_q   <= '0;
      overrun_q   <= 1'b0;
      mon_state_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        acc_q[i]   <= '0;
`ifdef LIF_REFRACTORY_EN
        refr_q[i]  <= 2'd0;
`endif
      end
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      spk_valid_q <= spk_valid_d;
      spk_idx_q   <= spk_idx_d;
      overrun_q   <= overrun_d;
      mon_state_q <= mon_state_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
`ifdef LIF_REFRACTORY_EN
      refr_q      <= refr_d;
`endif
    end
  end

  assign cur_ready = (fsm_q == IDLE);
  assign busy      = (fsm_q == SWEEP);
  assign done      = (fsm_q == DONE);
  assign overrun   = overrun_q;
  assign spk_valid = spk_valid_q;
  assign spk_idx   = spk_idx_q;
  assign mon_state = mon_state_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed self-checking bench for lif_scheduler (N=4, W=8, THRESHOLD=200, LEAK_SHIFT=2).
// Expected values are hand-computed; the refractory scenario adapts to LIF_REFRACTORY_EN.
module tb_lif_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cur_valid;
  logic [1:0] cur_idx;
  logic [7:0] cur_data;
  logic       cur_ready;
  logic       tick;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       spk_valid;
  logic [1:0] spk_idx;
  logic       spk_ready;
  logic [1:0] mon_idx;
  logic [7:0] mon_state;

  int checks = 0;
  int errors = 0;

  lif_scheduler #(
    .N_NEURONS (4),
    .W         (8),
    .THRESHOLD (200),
    .LEAK_SHIFT(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cur_valid(cur_valid),
    .cur_idx  (cur_idx),
    .cur_data (cur_data),
    .cur_ready(cur_ready),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .spk_valid(spk_valid),
    .spk_idx  (spk_idx),
    .spk_ready(spk_ready),
    .mon_idx  (mon_idx),
    .mon_state(mon_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic [7:0] data);
    cur_valid = 1'b1;
    cur_idx   = idx;
    cur_data  = data;
    step();
    cur_valid = 1'b0;
  endtask

  // Leaves the bench in cycle t+1 relative to the tick cycle t.
  task automatic runTick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic readState(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    mon_idx = idx;
    step();
    checkOutput(tag, 32'(mon_state), 32'(exp));
  endtask

  initial begin
    rst_n     = 1'b0;
    cur_valid = 1'b0;
    cur_idx   = '0;
    cur_data  = '0;
    tick      = 1'b0;
    spk_ready = 1'b0;
    mon_idx   = '0;
    step();
    step();

    $display("[TB] reset values");
    checkOutput("rst_cur_ready", 32'(cur_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_spk_valid", 32'(spk_valid), 0);
    checkOutput("rst_spk_idx", 32'(spk_idx), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) readState("rst_mon_state", 2'(i), 8'd0);

    $display("[TB] integrate without spike");
    doReset();
    applyStimulus(2'd1, 8'd100);
    runTick();
    checkOutput("s1_busy_t1", 32'(busy), 1);
    checkOutput("s1_cur_ready_t1", 32'(cur_ready), 0);
    step(); step(); step();
    checkOutput("s1_busy_t4", 32'(busy), 1);
    checkOutput("s1_done_t4", 32'(done), 0);
    step();
    checkOutput("s1_done_t5", 32'(done), 1);
    checkOutput("s1_busy_t5", 32'(busy), 0);
    checkOutput("s1_spk_valid", 32'(spk_valid), 0);
    step();
    checkOutput("s1_done_t6", 32'(done), 0);
    readState("s1_state1", 2'd1, 8'd100);
    runTick();
    step(); step(); step(); step(); step();
    readState("s1_state1_leak", 2'd1, 8'd75);

    $display("[TB] saturating accumulate and spike");
    doReset();
    applyStimulus(2'd2, 8'd200);
    applyStimulus(2'd2, 8'd100);
    runTick();
    step(); step();
    checkOutput("s2_spk_valid_t3", 32'(spk_valid), 0);
    step();
    checkOutput("s2_spk_valid_t4", 32'(spk_valid), 1);
    checkOutput("s2_spk_idx_t4", 32'(spk_idx), 2);
    step();
    checkOutput("s2_done_t5", 32'(done), 1);
    checkOutput("s2_spk_hold_t5", 32'(spk_valid), 1);
    spk_ready = 1'b1;
    step();
    spk_ready = 1'b0;
    checkOutput("s2_spk_drained", 32'(spk_valid), 0);
    readState("s2_state2", 2'd2, 8'd0);
    runTick();
    step(); step(); step(); step(); step();
    checkOutput("s2_acc_cleared", 32'(spk_valid), 0);
    readState("s2_state2_again", 2'd2, 8'd0);

    $display("[TB] backpressure stall");
    doReset();
    applyStimulus(2'd0, 8'd220);
    applyStimulus(2'd3, 8'd220);
    spk_ready = 1'b0;
    runTick();
    checkOutput("s3_spk_valid_t1", 32'(spk_valid), 0);
    step();
    checkOutput("s3_spk_valid_t2", 32'(spk_valid), 1);
    checkOutput("s3_spk_idx_t2", 32'(spk_idx), 0);
    step(); step(); step();
    checkOutput("s3_busy_t5", 32'(busy), 1);
    checkOutput("s3_done_t5", 32'(done), 0);
    step();
    checkOutput("s3_busy_t6", 32'(busy), 1);
    checkOutput("s3_spk_idx_t6", 32'(spk_idx), 0);
    step();
    spk_ready = 1'b1;
    step();
    checkOutput("s3_done_release", 32'(done), 1);
    checkOutput("s3_spk_valid_second", 32'(spk_valid), 1);
    checkOutput("s3_spk_idx_second", 32'(spk_idx), 3);
    step();
    checkOutput("s3_spk_drained", 32'(spk_valid), 0);
    spk_ready = 1'b0;
    readState("s3_state0", 2'd0, 8'd0);
    readState("s3_state3", 2'd3, 8'd0);

    $display("[TB] overrun");
    doReset();
    runTick();
    checkOutput("s4_overrun_t1", 32'(overrun), 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    checkOutput("s4_overrun_t3", 32'(overrun), 1);
    step(); step();
    checkOutput("s4_done_t5", 32'(done), 1);
    step(); step();
    checkOutput("s4_no_second_sweep", 32'(busy), 0);
    checkOutput("s4_overrun_sticky", 32'(overrun), 1);

    $display("[TB] reset mid-sweep");
    doReset();
    applyStimulus(2'd0, 8'd255);
    spk_ready = 1'b0;
    runTick();
    step();
    checkOutput("s5_spk_valid_t2", 32'(spk_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_spk_valid", 32'(spk_valid), 0);
    checkOutput("s5_rst_busy", 32'(busy), 0);
    checkOutput("s5_rst_cur_ready", 32'(cur_ready), 1);
    step();
    rst_n = 1'b1;
    spk_ready = 1'b1;
    step(); step(); step(); step();
    checkOutput("s5_no_spike", 32'(spk_valid), 0);
    checkOutput("s5_idle", 32'(busy), 0);
    spk_ready = 1'b0;
    readState("s5_state0", 2'd0, 8'd0);

    $display("[TB] repeated drive on neuron 2");
    doReset();
    spk_ready = 1'b0;
    applyStimulus(2'd2, 8'd255);
    runTick();
    step(); step(); step();
    checkOutput("s6_first_spike", 32'(spk_valid), 1);
    spk_ready = 1'b1;
    step(); step();
    spk_ready = 1'b0;
    applyStimulus(2'd2, 8'd255);
    runTick();
    step(); step(); step();
`ifdef LIF_REFRACTORY_EN
    checkOutput("s6_second_spike", 32'(spk_valid), 0);
`else
    checkOutput("s6_second_spike", 32'(spk_valid), 1);
    checkOutput("s6_second_idx", 32'(spk_idx), 2);
`endif
    readState("s6_state2", 2'd2, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed controller that shares one leaky-integrate-fire update datapath across `N_NEURONS` virtual neurons. It buffers incoming synaptic current per neuron between timesteps. On each `tick` it sweeps all neurons in index order, one update per cycle, and emits spike events over a valid/ready port with backpressure. It sits between the pin-level wrapper (current injection, spike readout) and the shared update core, and replaces one-neuron-per-instance replication.

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons, power of two, 2..16.
- `W`, 8: membrane and current width.
- `THRESHOLD`, 200: spike when updated state >= THRESHOLD.
- `LEAK_SHIFT`, 2: leak per tick is `state >> LEAK_SHIFT`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cur_valid`  in  1  current-injection request.
- `cur_idx`  in  log2(N)  target neuron.
- `cur_data`  in  W  current to add, unsigned.
- `cur_ready`  out  1  injection accepted when `cur_valid && cur_ready`.
- `tick`  in  1  single-cycle timestep pulse.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last neuron commits.
- `overrun`  out  1  sticky; set when `tick` arrives while busy.
- `spk_valid`  out  1  spike event pending.
- `spk_idx`  out  log2(N)  neuron that fired.
- `spk_ready`  in  1  consumer accepts the event.
- `mon_idx`  in  log2(N)  monitor select.
- `mon_state`  out  W  registered `state[mon_idx]`, 1-cycle latency.

## Operation
- Per-neuron storage: `state[i]` (W bits) and `acc[i]` (W bits).
- FSM states:
  - IDLE -> SWEEP on `tick`; index reset to 0.
  - SWEEP -> DONE after index N-1 commits.
  - DONE -> IDLE unconditionally.
- Injection:
  - `cur_ready` = 1 only in IDLE.
  - An accepted injection does `acc[cur_idx] = min(acc + cur_data, 2^W-1)` (saturating).
- Update at index i (shared core, combinational):
  - `v = state - (state >> LEAK_SHIFT) + acc`, computed at W+1 bits and saturated to 2^W-1.
  - If `v >= THRESHOLD`: spike is produced and `state <= 0`.
  - Otherwise `state <= v`.
  - `acc[i] <= 0` on commit.
- Spike output: one-entry output register.
  - A spiking neuron commits only if the register is empty or is being drained that cycle (`!spk_valid || spk_ready`). Otherwise the sweep stalls at index i with no state change.
  - Non-spiking neurons never stall.
- `tick` in SWEEP or DONE is ignored and sets `overrun`. `overrun` clears only on reset.
- `tick` coincident with `cur_valid` in IDLE: the injection is accepted and included in the sweep that starts next cycle.
- Spike events are delivered in strictly ascending index order within a sweep.

## Timing
- Reset values: all `state`, `acc`, `spk_valid`, `spk_idx`, `busy`, `done`, `overrun` and `mon_state` = 0. `cur_ready` = 1. FSM = IDLE.
- Sweep timing:
  - `tick` sampled at cycle t; SWEEP spans t+1..t+N with no backpressure.
  - `done` is high at t+N+1; `busy` is high t+1..t+N.
- Spike latency: neuron i commits at t+1+i and `spk_valid` rises at t+2+i.
- `spk_valid`/`spk_idx` stay stable until `spk_ready`. A transfer occurs when both are high.
- Reset mid-sweep: everything returns to reset values immediately, and the pending spike is discarded.

## Configuration
- `LIF_REFRACTORY_EN`:
  - Defined: each neuron gets a 2-bit refractory counter, loaded with 2 on spike. While the counter is nonzero, the neuron's update forces `state <= 0`, discards `acc`, never spikes and decrements the counter.
  - Undefined: no counters, and neurons are eligible to spike every tick.

## Structure
- Package `lif_pkg`:
  - FSM state enum (IDLE, SWEEP, DONE).
  - Default W, THRESHOLD and LEAK_SHIFT constants.
  - Saturating-add helper function.
- Sub-module `lif_update_core`: purely combinational leak/integrate/threshold. Inputs are state, acc and refractory count; outputs are next state, spike and next count. It is instantiated once.
- The scheduler holds the FSM, index counter, storage arrays, spike register and monitor register.

## Test plan
All scenarios use N=4, W=8, THRESHOLD=200, LEAK_SHIFT=2.
- Reset: all outputs at reset values and `mon_state` = 0 for every `mon_idx`.
- Inject 100 to neuron 1, then tick -> `state[1]` = 100, no spike, `done` at t+5. A second tick with no input -> `state[1]` = 75.
- Inject 200 then 100 to neuron 2 (acc saturates at 255), then tick -> one spike with `spk_idx` = 2 at t+4. `state[2]` = 0 and `acc[2]` = 0.
- Inject 220 to neurons 0 and 3, hold `spk_ready` low 6 cycles after tick -> sweep stalls at index 3 with `busy` held. Events are delivered in order 0 then 3, and `done` follows the stall release.
- Tick at t+2 during a sweep -> ignored, `overrun` = 1 and stays 1. No second sweep starts.
- Reset asserted at t+2 of a spiking sweep -> all outputs return to reset values next edge and no spike is delivered. With `LIF_REFRACTORY_EN`, neuron 2 fed 255 on two consecutive ticks spikes only on the first.
